// File: rtl/serial_borrow_subtractor_if.sv
// Operand/result bundle for the bit-serial borrow subtractor.
// The master issues start/a/b/bin and the slave returns busy/done/diff/bout/ovf.
interface serial_borrow_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial ripple-borrow subtractor: a - b - bin, one bit per clock, LSB first,
// with the borrow carried in a flip-flop; result flagged by a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; diff/bout/ovf hold the last result
// BUSY  | processing bit cnt of the latched operands
// DONE  | done pulse cycle; diff/bout/ovf valid
module serial_borrow_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_borrow_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic d_bit;
    logic br_nxt;

    // One full-subtractor cell; operands are consumed from bit 0 of the shift registers.
    assign d_bit  = sa[0] ^ sb[0] ^ br;
    assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        br     <= bus.bin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    br     <= br_nxt;
                    diff_q <= {d_bit, diff_q[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // On the last bit sa[0]/sb[0] are the operand sign bits.
                        bout_q <= br_nxt;
                        ovf_q  <= (sa[0] ^ sb[0]) & (d_bit ^ sa[0]);
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Scoreboard bench for serial_borrow_subtractor: stimulus pushes expected results,
// a negedge monitor pops and compares them on every done pulse.
module tb_serial_borrow_subtractor;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   next_free = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    exp_t q[$];

    serial_borrow_subtractor_if #(.WIDTH(W)) bus ();

    serial_borrow_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: plain integer arithmetic on the unsigned and signed views.
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic bin, int c);
        exp_t e;
        int ua, ub, r, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        r  = ua - ub - int'(bin);
        e.diff = W'(r);
        e.bout = (r < 0);
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        sr = sa - sb - int'(bin);
        e.ovf = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        e.cyc = c;
        return e;
    endfunction

    // Drive start for one cycle; the bench decides from its own timeline whether it is accepted.
    task automatic issue(logic [W-1:0] av, logic [W-1:0] bv, logic binv);
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.bin   = binv;
        if (rst_n && (cyc + 1 >= next_free)) begin
            q.push_back(model(av, bv, binv, cyc + 1 + W));
            next_free = cyc + 1 + W + 2;
            busy_lo   = cyc + 1;
            busy_hi   = cyc + W;
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            bus.start = 1'b0;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.bin   = 1'($urandom);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_diff"}, bus.diff, 0);
        chk({tag, "_bout"}, bus.bout, 0);
        chk({tag, "_ovf"},  bus.ovf,  0);
    endtask

    task automatic pulse_reset(int n);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.start = 1'b0;
        q.delete();
        next_free = 0;
        busy_lo   = 1;
        busy_hi   = 0;
        #1;
        check_reset_outputs("async_rst");
        repeat (n) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            exp_t e;
            chk("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("diff", bus.diff, e.diff);
                    chk("bout", bus.bout, e.bout);
                    chk("ovf", bus.ovf, e.ovf);
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                e = q.pop_front();
                chk("missing_done", cyc, e.cyc);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        issue(8'h10, 8'h01, 1'b0); idle(12);
        issue(8'h00, 8'h01, 1'b0); idle(12);
        issue(8'hFF, 8'hFF, 1'b1); idle(12);
        issue(8'h80, 8'h01, 1'b0); idle(12);
        issue(8'h80, 8'h7F, 1'b1); idle(12);

        // Start pulse mid-operation must be ignored.
        issue(8'h55, 8'h22, 1'b0); idle(3);
        issue(8'h00, 8'hFF, 1'b0); idle(12);

        // Reset three cycles into an operation aborts it without a done pulse.
        issue(8'hAA, 8'h11, 1'b1); idle(2);
        pulse_reset(3);
        idle(2);
        issue(8'h7F, 8'h7F, 1'b1); idle(12);

        // Start held high: accepted every WIDTH+2 cycles.
        for (int i = 0; i < 45; i++) issue(W'($urandom), W'($urandom), 1'($urandom));
        idle(12);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) issue(W'($urandom), W'($urandom), 1'($urandom));
            else idle(1);
        end
        idle(2);

        for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
